// File: rtl/secuenciador_multiciclo.sv
// ---------------------------------------------------------------------------
// secuenciador_multiciclo
//
// Multicycle control sequencer for an RV32 subset (lui, add/sub, addi, load,
// store, beq). It steps a shared datapath through FETCH, DECODE, EXEC, MEM
// and WB, and shares one instruction/data memory port through a
// mem_req/mem_ready handshake. It also keeps a retired-instruction counter
// and a sticky trap. The trap fires on an illegal opcode or when memory
// fails to answer in time.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   run          enable, looked at only between instructions
//   opcode       opcode field of the instruction register
//   funct7_5     instr[30]: add (0) / sub (1) for R-type
//   cero         ALU zero flag
//   mem_ready    memory finishes the current request this cycle
//   mem_req      memory request
//   mem_we       memory write (only meaningful with mem_req)
//   addr_sel     memory address: 0 = PC, 1 = ALU result
//   ir_wr        load the instruction register
//   pc_wr        update PC (marks the retire cycle)
//   pc_sel       PC source: 0 = PC+4, 1 = branch target
//   reg_wr       register file write
//   alu_sub      ALU subtract
//   alu_b_sel    ALU B: 00 = rs2, 01 = I-imm, 10 = S-imm
//   wb_sel       writeback: 00 = U-imm, 01 = ALU, 10 = memory
//   trap         sticky fault flag
//   trap_cause   0 = illegal opcode, 1 = memory timeout
//   state        current FSM state code
//   instr_count  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module secuenciador_multiciclo #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             funct7_5,
   input  logic             cero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_wr,
   output logic             pc_wr,
   output logic             pc_sel,
   output logic             reg_wr,
   output logic             alu_sub,
   output logic [1:0]       alu_b_sel,
   output logic [1:0]       wb_sel,
   output logic             trap,
   output logic             trap_cause,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CL_NONE   = 3'd0,
      CL_LUI    = 3'd1,
      CL_R      = 3'd2,
      CL_ADDI   = 3'd3,
      CL_LOAD   = 3'd4,
      CL_STORE  = 3'd5,
      CL_BRANCH = 3'd6
   } cls_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t            state_q;
   state_t            state_d;
   cls_t              cls_q;
   cls_t              dec_cls;
   logic              f7_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout;
   logic              retire_next;
   logic              trap_set;
   logic              trap_cause_set;

   // Map the raw opcode to an instruction class. CL_NONE marks an illegal
   // opcode. The class is only latched in DECODE.
   always_comb begin
      dec_cls = CL_NONE;
      unique case (opcode)
         OP_LUI:    dec_cls = CL_LUI;
         OP_R:      dec_cls = CL_R;
         OP_ADDI:   dec_cls = CL_ADDI;
         OP_LOAD:   dec_cls = CL_LOAD;
         OP_STORE:  dec_cls = CL_STORE;
         OP_BRANCH: dec_cls = CL_BRANCH;
         default:   dec_cls = CL_NONE;
      endcase
   end

   // A timeout fires in the cycle that would be the MEM_TIMEOUT-th
   // consecutive wait cycle. mem_ready in that same cycle counts as
   // completion, not as a timeout.
   assign timeout = !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   // After a retire, run decides between the next fetch and idling.
   assign retire_next = run;

   // Next-state and strobe decode. Every strobe defaults to 0 so that each
   // state only lists what it drives. The rst_n gate at the end keeps
   // strobes quiet while reset is held, even if the reset arrives in the
   // middle of an instruction.
   always_comb begin
      state_d        = state_q;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      addr_sel       = 1'b0;
      ir_wr          = 1'b0;
      pc_wr          = 1'b0;
      pc_sel         = 1'b0;
      reg_wr         = 1'b0;
      alu_sub        = 1'b0;
      alu_b_sel      = 2'b00;
      wb_sel         = 2'b00;
      trap_set       = 1'b0;
      trap_cause_set = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end

         FETCH: begin
            mem_req  = 1'b1;
            addr_sel = 1'b0;
            if (mem_ready) begin
               ir_wr   = 1'b1;
               state_d = DECODE;
            end else if (timeout) begin
               state_d        = TRAP;
               trap_set       = 1'b1;
               trap_cause_set = 1'b1;
            end
         end

         DECODE: begin
            if (dec_cls == CL_NONE) begin
               state_d        = TRAP;
               trap_set       = 1'b1;
               trap_cause_set = 1'b0;
            end else begin
               state_d = EXEC;
            end
         end

         EXEC: begin
            unique case (cls_q)
               CL_R: begin
                  alu_b_sel = 2'b00;
                  alu_sub   = f7_q;
                  state_d   = WB;
               end
               CL_ADDI: begin
                  alu_b_sel = 2'b01;
                  state_d   = WB;
               end
               CL_LUI: begin
                  state_d = WB;
               end
               CL_LOAD: begin
                  alu_b_sel = 2'b01;
                  state_d   = MEM;
               end
               CL_STORE: begin
                  alu_b_sel = 2'b10;
                  state_d   = MEM;
               end
               CL_BRANCH: begin
                  // beq retires right here: the ALU compares rs1-rs2 and
                  // the zero flag picks the PC source.
                  alu_b_sel = 2'b00;
                  alu_sub   = 1'b1;
                  pc_wr     = 1'b1;
                  pc_sel    = cero;
                  state_d   = retire_next ? FETCH : IDLE;
               end
               default: begin
                  state_d        = TRAP;
                  trap_set       = 1'b1;
                  trap_cause_set = 1'b0;
               end
            endcase
         end

         MEM: begin
            // The ALU keeps computing the address, so B stays on the
            // immediate chosen in EXEC for the whole access.
            mem_req   = 1'b1;
            addr_sel  = 1'b1;
            mem_we    = (cls_q == CL_STORE);
            alu_b_sel = (cls_q == CL_STORE) ? 2'b10 : 2'b01;
            if (mem_ready) begin
               if (cls_q == CL_STORE) begin
                  pc_wr   = 1'b1;
                  pc_sel  = 1'b0;
                  state_d = retire_next ? FETCH : IDLE;
               end else begin
                  state_d = WB;
               end
            end else if (timeout) begin
               state_d        = TRAP;
               trap_set       = 1'b1;
               trap_cause_set = 1'b1;
            end
         end

         WB: begin
            reg_wr = 1'b1;
            pc_wr  = 1'b1;
            pc_sel = 1'b0;
            unique case (cls_q)
               CL_LUI:  wb_sel = 2'b00;
               CL_LOAD: wb_sel = 2'b10;
               default: wb_sel = 2'b01;
            endcase
            state_d = retire_next ? FETCH : IDLE;
         end

         TRAP: begin
            state_d = TRAP;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (!rst_n) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         addr_sel  = 1'b0;
         ir_wr     = 1'b0;
         pc_wr     = 1'b0;
         pc_sel    = 1'b0;
         reg_wr    = 1'b0;
         alu_sub   = 1'b0;
         alu_b_sel = 2'b00;
         wb_sel    = 2'b00;
      end
   end

   // State register, class latch, wait counter, sticky trap and the retire
   // counter. The wait counter restarts on every state change, so FETCH and
   // MEM each get their own full timeout budget.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cls_q       <= CL_NONE;
         f7_q        <= 1'b0;
         wait_cnt    <= '0;
         trap        <= 1'b0;
         trap_cause  <= 1'b0;
         instr_count <= '0;
      end else begin
         state_q <= state_d;

         if (state_q == DECODE) begin
            cls_q <= dec_cls;
            f7_q  <= funct7_5;
         end

         if (state_d != state_q) begin
            wait_cnt <= '0;
         end else if ((state_q == FETCH || state_q == MEM) && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end

         if (trap_set) begin
            trap       <= 1'b1;
            trap_cause <= trap_cause_set;
         end

         if (pc_wr) begin
            instr_count <= instr_count + CNT_W'(1);
         end
      end
   end

   assign state = state_q;

endmodule

// File: doc/secuenciador_multiciclo.md
Name: secuenciador_multiciclo

Overview:
- Multicycle control sequencer for the RV32 core subset: lui, R-type add/sub, addi, load, store, beq.
- Replaces single-cycle decode with an FSM that steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with a shared instruction/data memory port using mem_req/mem_ready.
- Provides a retired-instruction counter and a sticky trap for illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: number of consecutive cycles waiting for mem_ready before a timeout trap.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  enable; sampled only at instruction boundaries.
- opcode  in  7  opcode field from the instruction register.
- funct7_5  in  1  instr[30]; selects add (0) or sub (1) for R-type.
- cero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write; valid only with mem_req.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_wr  out  1  load the instruction register.
- pc_wr  out  1  update PC.
- pc_sel  out  1  PC source: 0 = PC+4, 1 = branch target.
- reg_wr  out  1  register file write.
- alu_sub  out  1  ALU subtract.
- alu_b_sel  out  2  ALU B operand: 00 = rs2, 01 = I-immediate, 10 = S-immediate.
- wb_sel  out  2  writeback source: 00 = U-immediate, 01 = ALU, 10 = memory.
- trap  out  1  sticky fault.
- trap_cause  out  1  0 = illegal opcode, 1 = memory timeout.
- state  out  3  current FSM state code.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Outputs are a combinational decode of state, the latched class, cero and mem_ready. All outputs not listed for a state are 0.
- Reset: while rst_n=0, all strobes are forced to 0. At the edge: state=IDLE, instr_count=0, wait counter=0, trap=0, trap_cause=0, class register cleared. Reset applies from any state, including mid-instruction and TRAP.
- IDLE: if run=1, go to FETCH next cycle; otherwise hold.
- FETCH:
  - mem_req=1, addr_sel=0.
  - When mem_ready=1: ir_wr=1 in the same cycle, then go to DECODE.
- DECODE (1 cycle):
  - Latch the opcode class and funct7_5.
  - Legal opcodes: 0110111, 0110011, 0010011, 0000011, 0100011, 1100011. A legal opcode goes to EXEC.
  - Any other opcode goes to TRAP with trap_cause=0.
- EXEC (1 cycle), per class:
  - R-type: alu_b_sel=00, alu_sub=funct7_5, go to WB.
  - addi: alu_b_sel=01, go to WB.
  - lui: go to WB; no ALU use.
  - load: alu_b_sel=01, go to MEM.
  - store: alu_b_sel=10, go to MEM.
  - branch: alu_b_sel=00, alu_sub=1, pc_wr=1, pc_sel=cero; the instruction retires and the FSM proceeds to the next instruction.
- MEM:
  - mem_req=1, addr_sel=1, alu_b_sel held from EXEC, mem_we=1 for store.
  - On mem_ready: a load goes to WB.
  - On mem_ready for a store: pc_wr=1, pc_sel=0, the store retires, and the FSM proceeds to the next instruction.
- WB (1 cycle): reg_wr=1; wb_sel = 00 for lui, 01 for R-type/addi, 10 for load; pc_wr=1, pc_sel=0; the instruction retires.
- Next instruction: on retire, go to FETCH if run=1, else IDLE. Deasserting run never aborts an in-flight instruction.
- Latency with mem_ready=1 on first request: branch 3 cycles; R-type, addi, lui and store 4; load 5. Each wait cycle adds 1.
- Retire: the cycle pc_wr=1. instr_count increments by 1 and wraps modulo 2^CNT_W.
- Timeout:
  - The wait counter increments each cycle in FETCH or MEM with mem_ready=0, and clears on any state change.
  - If it reaches MEM_TIMEOUT while mem_ready=0, go to TRAP with trap_cause=1.
  - mem_ready=1 in the same cycle the counter would hit the limit counts as completion, not a timeout.
- TRAP: trap=1; all strobes 0; held until reset. Ignores run and mem_ready.
- mem_ready is ignored outside FETCH and MEM.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=0110011, funct7_5=1 → states 1,2,3,5 then 1. In EXEC: alu_sub=1, alu_b_sel=00. In WB: reg_wr=1, wb_sel=01, pc_wr=1. instr_count=1.
- Load with mem_ready low for 3 cycles in MEM → MEM occupies 4 cycles. mem_req=1, addr_sel=1, mem_we=0 throughout. WB has wb_sel=10. Total latency 8 cycles.
- Branch with cero=1, then another with cero=0 → EXEC shows pc_wr=1 with pc_sel=1, then pc_sel=0. reg_wr and mem_req stay 0. instr_count +2.
- opcode=1111111 → TRAP after DECODE: trap=1, trap_cause=0, all strobes 0. Pulse rst_n=0 for 1 cycle → state=0, instr_count=0, trap=0.
- mem_ready held 0 in FETCH → TRAP entered after exactly 15 wait cycles with trap_cause=1. Repeat with mem_ready=1 on the 15th cycle → no trap.
- run dropped during a store's MEM wait → the store completes (mem_we=1, then pc_wr=1), FSM goes to IDLE and holds. run=1 → FETCH. Also assert rst_n=0 mid-EXEC → no reg_wr or pc_wr pulse, state=IDLE.
